// File: rtl/can_frame_sequencer.sv
// CAN 2.0A base-format field sequencer: walks SOF..EOF(/IFS), counting only non-stuff bits.
// Build option: define CAN_SEQ_IFS_EN to append the 3-bit intermission field before frame_done.
module can_frame_sequencer (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       tx_request,
  input  logic       frame_type_in,
  input  logic [3:0] dlc_in,
  input  logic       sample_point,
  input  logic       stuff_bit_inserted,
  input  logic       bit_error,
  input  logic       arbitration_lost,
  output logic [3:0] field,
  output logic       field_start,
  output logic [5:0] bit_index,
  output logic       stuff_enable,
  output logic       crc_enable,
  output logic       busy,
  output logic       tx_ack,
  output logic       frame_done,
  output logic       frame_abort,
  output logic       frame_type_out,
  output logic [3:0] dlc_out
);

  typedef enum logic [3:0] {
    F_IDLE    = 4'd0,
    F_SOF     = 4'd1,
    F_ID      = 4'd2,
    F_RTR     = 4'd3,
    F_IDE     = 4'd4,
    F_R0      = 4'd5,
    F_DLC     = 4'd6,
    F_DATA    = 4'd7,
    F_CRC     = 4'd8,
    F_CRC_DEL = 4'd9,
    F_ACK     = 4'd10,
    F_ACK_DEL = 4'd11,
`ifdef CAN_SEQ_IFS_EN
    F_EOF     = 4'd12,
    F_IFS     = 4'd13
`else
    F_EOF     = 4'd12
`endif
  } field_t;

  field_t     field_q, field_d, field_next;
  logic [5:0] idx_d, last_idx, data_last;
  logic [3:0] data_bytes, dlc_d;
  logic       start_d, ack_d, done_d, abort_d, type_d, stuff_d, crc_d;
  logic       qual, skip_data, abort_req;

  assign field     = field_q;
  assign qual      = sample_point && !stuff_bit_inserted;
  assign skip_data = frame_type_out || (dlc_out == 4'd0);
  assign abort_req = bit_error || (arbitration_lost && (field_q == F_ID || field_q == F_RTR));

  // DLC 9..15 saturates to 8 bytes; raw value stays on dlc_out
  assign data_bytes = dlc_out[3] ? 4'd8 : dlc_out;
  assign data_last  = 6'({data_bytes, 3'b000} - 7'd1);

  always_comb begin
    case (field_q)
      F_ID:    last_idx = 6'd10;
      F_DLC:   last_idx = 6'd3;
      F_DATA:  last_idx = data_last;
      F_CRC:   last_idx = 6'd14;
      F_EOF:   last_idx = 6'd6;
`ifdef CAN_SEQ_IFS_EN
      F_IFS:   last_idx = 6'd2;
`endif
      default: last_idx = 6'd0;
    endcase
  end

  always_comb begin
    case (field_q)
      F_SOF:     field_next = F_ID;
      F_ID:      field_next = F_RTR;
      F_RTR:     field_next = F_IDE;
      F_IDE:     field_next = F_R0;
      F_R0:      field_next = F_DLC;
      F_DLC:     field_next = skip_data ? F_CRC : F_DATA;
      F_DATA:    field_next = F_CRC;
      F_CRC:     field_next = F_CRC_DEL;
      F_CRC_DEL: field_next = F_ACK;
      F_ACK:     field_next = F_ACK_DEL;
      F_ACK_DEL: field_next = F_EOF;
`ifdef CAN_SEQ_IFS_EN
      F_EOF:     field_next = F_IFS;
`endif
      default:   field_next = F_IDLE;
    endcase
  end

  always_comb begin
    field_d = field_q;
    idx_d   = bit_index;
    start_d = 1'b0;
    ack_d   = 1'b0;
    done_d  = 1'b0;
    abort_d = 1'b0;
    type_d  = frame_type_out;
    dlc_d   = dlc_out;
    if (!enable) begin
      field_d = F_IDLE;
      idx_d   = '0;
      type_d  = 1'b0;
      dlc_d   = '0;
    end else if (field_q == F_IDLE) begin
      if (tx_request) begin
        field_d = F_SOF;
        idx_d   = '0;
        start_d = 1'b1;
        ack_d   = 1'b1;
        type_d  = frame_type_in;
        dlc_d   = dlc_in;
      end
    end else if (abort_req) begin
      field_d = F_IDLE;
      idx_d   = '0;
      abort_d = 1'b1;
    end else if (qual) begin
      if (bit_index == last_idx) begin
        field_d = field_next;
        idx_d   = '0;
        if (field_next == F_IDLE) done_d = 1'b1;
        else                      start_d = 1'b1;
      end else begin
        idx_d = bit_index + 6'd1;
      end
    end
  end

  // enables decoded from the next field so they register alongside it
  assign stuff_d = (field_d != F_IDLE) && (field_d <= F_CRC);
  assign crc_d   = (field_d != F_IDLE) && (field_d <= F_DATA);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      field_q        <= F_IDLE;
      bit_index      <= '0;
      field_start    <= 1'b0;
      stuff_enable   <= 1'b0;
      crc_enable     <= 1'b0;
      busy           <= 1'b0;
      tx_ack         <= 1'b0;
      frame_done     <= 1'b0;
      frame_abort    <= 1'b0;
      frame_type_out <= 1'b0;
      dlc_out        <= '0;
    end else begin
      field_q        <= field_d;
      bit_index      <= idx_d;
      field_start    <= start_d;
      stuff_enable   <= stuff_d;
      crc_enable     <= crc_d;
      busy           <= (field_d != F_IDLE);
      tx_ack         <= ack_d;
      frame_done     <= done_d;
      frame_abort    <= abort_d;
      frame_type_out <= type_d;
      dlc_out        <= dlc_d;
    end
  end

endmodule

// File: tb/tb_can_frame_sequencer.sv
// Bench for can_frame_sequencer: frame model built from field-length tables plus directed literal checks.
module tb_can_frame_sequencer;

  logic       clock = 1'b0;
  logic       reset_n, enable, tx_request, frame_type_in;
  logic [3:0] dlc_in;
  logic       sample_point, stuff_bit_inserted, bit_error, arbitration_lost;
  logic [3:0] field;
  logic       field_start;
  logic [5:0] bit_index;
  logic       stuff_enable, crc_enable, busy, tx_ack, frame_done, frame_abort, frame_type_out;
  logic [3:0] dlc_out;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef CAN_SEQ_IFS_EN
  localparam int          BITS_DLC1   = 55;
  localparam int          BITS_RTR5   = 47;
  localparam int          BITS_DLC12  = 111;
  localparam logic [63:0] SIG_DATA    = 64'h1_2345_6789_ABCD;
  localparam logic [63:0] SIG_REMOTE  = 64'h1234_5689_ABCD;
`else
  localparam int          BITS_DLC1   = 52;
  localparam int          BITS_RTR5   = 44;
  localparam int          BITS_DLC12  = 108;
  localparam logic [63:0] SIG_DATA    = 64'h1234_5678_9ABC;
  localparam logic [63:0] SIG_REMOTE  = 64'h1_2345_689A_BC;
`endif

  can_frame_sequencer dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .tx_request(tx_request),
    .frame_type_in(frame_type_in), .dlc_in(dlc_in), .sample_point(sample_point),
    .stuff_bit_inserted(stuff_bit_inserted), .bit_error(bit_error),
    .arbitration_lost(arbitration_lost), .field(field), .field_start(field_start),
    .bit_index(bit_index), .stuff_enable(stuff_enable), .crc_enable(crc_enable),
    .busy(busy), .tx_ack(tx_ack), .frame_done(frame_done), .frame_abort(frame_abort),
    .frame_type_out(frame_type_out), .dlc_out(dlc_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- frame model: cumulative bit position into a list of fields
  int         m_seq[$];
  logic       m_active;
  int         m_pos, m_total;
  logic [3:0] m_dlc;
  logic [3:0] e_field, e_dlc;
  logic [5:0] e_idx;
  logic       e_start, e_busy, e_ack, e_done, e_abort, e_type;

  function automatic int flen(input int code, input logic [3:0] dlc);
    case (code)
      2: return 11;
      6: return 4;
      7: return 8 * ((dlc > 8) ? 8 : int'(dlc));
      8: return 15;
      12: return 7;
      13: return 3;
      default: return 1;
    endcase
  endfunction

  task automatic field_at(input int pos, output logic [3:0] f, output logic [5:0] idx);
    int base = 0;
    f = 4'd0;
    idx = 6'd0;
    foreach (m_seq[k]) begin
      if (pos < base + flen(m_seq[k], m_dlc)) begin
        f   = 4'(m_seq[k]);
        idx = 6'(pos - base);
        return;
      end
      base += flen(m_seq[k], m_dlc);
    end
  endtask

  always @(posedge clock or negedge reset_n) begin
    logic [3:0] nf;
    logic [5:0] ni;
    if (!reset_n) begin
      m_active = 0; m_pos = 0; m_total = 0; m_dlc = 0;
      e_field = 0; e_idx = 0; e_start = 0; e_busy = 0; e_ack = 0;
      e_done = 0; e_abort = 0; e_type = 0; e_dlc = 0;
    end else begin
      e_start = 0; e_ack = 0; e_done = 0; e_abort = 0;
      if (!enable) begin
        m_active = 0; e_field = 0; e_idx = 0; e_type = 0; e_dlc = 0;
      end else if (!m_active) begin
        if (tx_request) begin
          m_active = 1; m_pos = 0; m_dlc = dlc_in;
          e_type = frame_type_in; e_dlc = dlc_in;
          m_seq = {};
          for (int c = 1; c <= 12; c++)
            if (!(c == 7 && (frame_type_in || dlc_in == 0))) m_seq.push_back(c);
`ifdef CAN_SEQ_IFS_EN
          m_seq.push_back(13);
`endif
          m_total = 0;
          foreach (m_seq[k]) m_total += flen(m_seq[k], m_dlc);
          e_field = 4'd1; e_idx = 0; e_start = 1; e_ack = 1;
        end
      end else if (bit_error || (arbitration_lost && (e_field == 2 || e_field == 3))) begin
        m_active = 0; e_field = 0; e_idx = 0; e_abort = 1;
      end else if (sample_point && !stuff_bit_inserted) begin
        m_pos++;
        if (m_pos == m_total) begin
          m_active = 0; e_field = 0; e_idx = 0; e_done = 1;
        end else begin
          field_at(m_pos, nf, ni);
          e_start = (nf != e_field);
          e_field = nf;
          e_idx   = ni;
        end
      end
      e_busy = m_active;
    end
  end

  // ---------------- per-cycle compare plus field-start signature / DATA index tracking
  logic [63:0] sig;
  int          max_data_idx;

  always @(posedge clock) begin
    logic [21:0] act, exp;
    logic        e_stuff, e_crc;
    #1;
    if (reset_n) begin
      e_stuff = (e_field >= 1 && e_field <= 8);
      e_crc   = (e_field >= 1 && e_field <= 7);
      act = {field, bit_index, field_start, stuff_enable, crc_enable, busy, tx_ack,
             frame_done, frame_abort, frame_type_out, dlc_out};
      exp = {e_field, e_idx, e_start, e_stuff, e_crc, e_busy, e_ack,
             e_done, e_abort, e_type, e_dlc};
      check("cycle_outputs", 64'(act), 64'(exp));
      if (field_start) sig = tx_ack ? 64'(field) : {sig[59:0], field};
      if (tx_ack) max_data_idx = 0;
      if (field == 4'd7 && int'(bit_index) > max_data_idx) max_data_idx = int'(bit_index);
    end
  end

  // ---------------- stimulus
  task automatic do_cycle(input logic sp, input logic stf, input logic berr, input logic arb);
    @(negedge clock);
    sample_point = sp; stuff_bit_inserted = stf; bit_error = berr; arbitration_lost = arb;
    @(negedge clock);
    sample_point = 0; stuff_bit_inserted = 0; bit_error = 0; arbitration_lost = 0;
  endtask

  task automatic do_bits(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic request(input logic t, input logic [3:0] d);
    @(negedge clock);
    tx_request = 1; frame_type_in = t; dlc_in = d;
    @(negedge clock);
    tx_request = 0;
  endtask

  task automatic run_to_idle(output int n, output logic done_seen);
    n = 0; done_seen = 0;
    while (busy && n < 400) begin
      do_cycle(1'b1, 1'b0, 1'b0, 1'b0);
      n++;
      if (frame_done) done_seen = 1;
    end
  endtask

  initial begin
    int   n;
    logic dn;
    reset_n = 0; enable = 1; tx_request = 0; frame_type_in = 0; dlc_in = 0;
    sample_point = 0; stuff_bit_inserted = 0; bit_error = 0; arbitration_lost = 0;
    repeat (3) @(negedge clock);
    reset_n = 1;
    @(negedge clock);
    check("reset_state", 64'({field, bit_index, busy, field_start, stuff_enable, crc_enable, dlc_out}), 64'd0);

    // data frame, dlc 1
    request(1'b0, 4'd1);
    check("accept_field", 64'(field), 64'd1);
    check("accept_ack_start_busy", 64'({tx_ack, field_start, busy}), 64'b111);
    run_to_idle(n, dn);
    check("dlc1_bits", 64'(n), 64'(BITS_DLC1));
    check("dlc1_done", 64'(dn), 64'd1);
    check("dlc1_field_seq", sig, SIG_DATA);

    // remote frame, dlc 5: DATA skipped
    request(1'b1, 4'd5);
    run_to_idle(n, dn);
    check("rtr5_bits", 64'(n), 64'(BITS_RTR5));
    check("rtr5_field_seq", sig, SIG_REMOTE);
    check("rtr5_type_dlc", 64'({frame_type_out, dlc_out}), 64'h15);

    // data frame, dlc 12 saturates to 64 data bits
    request(1'b0, 4'd12);
    run_to_idle(n, dn);
    check("dlc12_bits", 64'(n), 64'(BITS_DLC12));
    check("dlc12_max_idx", 64'(max_data_idx), 64'd63);
    check("dlc12_dlc_out", 64'(dlc_out), 64'd12);

    // stuff bits inside ID are not counted
    request(1'b0, 4'd0);
    do_bits(1);
    for (int i = 0; i < 13; i++) do_cycle(1'b1, (i == 2 || i == 5 || i == 9), 1'b0, 1'b0);
    check("stuff_id_hold", 64'({field, bit_index}), {54'd0, 4'd2, 6'd10});
    do_bits(1);
    check("stuff_id_end", 64'({field, bit_index, field_start}), {53'd0, 4'd3, 6'd0, 1'b1});
    run_to_idle(n, dn);
    check("stuff_frame_done", 64'(dn), 64'd1);

    // arbitration_lost ignored in CRC; bit_error with qualified bit aborts
    request(1'b0, 4'd0);
    do_bits(19);
    check("crc_entry", 64'({field, bit_index}), {54'd0, 4'd8, 6'd0});
    do_bits(3);
    do_cycle(1'b1, 1'b0, 1'b0, 1'b1);
    do_bits(3);
    check("crc_arb_ignored", 64'({busy, field, bit_index}), {53'd0, 1'b1, 4'd8, 6'd7});
    do_cycle(1'b1, 1'b0, 1'b1, 1'b0);
    check("crc_abort", 64'({field, busy, frame_abort, frame_done}), {56'd0, 4'd0, 1'b0, 1'b1, 1'b0});

    // arbitration lost in ID aborts even off a sample point
    request(1'b0, 4'd3);
    do_bits(4);
    do_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("id_arb_abort", 64'({field, frame_abort}), {59'd0, 4'd0, 1'b1});

    // enable dropped in DATA
    request(1'b0, 4'd2);
    do_bits(22);
    check("data_reached", 64'({field, bit_index}), {54'd0, 4'd7, 6'd3});
    @(negedge clock);
    enable = 0;
    @(negedge clock);
    check("enable_drop_outputs", 64'({field, field_start, bit_index, stuff_enable, crc_enable, busy,
                                      tx_ack, frame_done, frame_abort, frame_type_out, dlc_out}), 64'd0);
    enable = 1;
    repeat (2) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/can_frame_sequencer.md
# can_frame_sequencer

Field-level sequencer for the CAN data/remote frame transmitter. It accepts a transmit request, walks the frame through SOF, identifier, RTR, control, data, CRC, ACK, EOF and intermission fields, and counts only non-stuff bits at each sample point. It drives per-field select and start pulses to the field modules (SOF, ID, RTR, DLC, data, CRC, ...) and gates the bit-stuffer and CRC unit. It sits between the frame request interface and the field modules, above the bit-timing and stuffing logic.

## Interface
Parameters:
- none; field lengths are fixed by CAN 2.0A base format.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  block enable; low forces IDLE and reset output values on the next clock edge.
- tx_request  in  1  level; a frame is requested while high.
- frame_type_in  in  1  0 = data frame, 1 = remote frame; sampled at acceptance.
- dlc_in  in  4  data length code; sampled at acceptance.
- sample_point  in  1  one-cycle pulse, one per bit time.
- stuff_bit_inserted  in  1  current bit is a stuff bit; do not count it.
- bit_error  in  1  bit error reported by the monitor.
- arbitration_lost  in  1  arbitration lost; honoured only in ID and RTR.
- field  out  4  current field code (see Operation).
- field_start  out  1  one-cycle pulse on the first cycle of each field.
- bit_index  out  6  index of the current non-stuff bit within the field.
- stuff_enable  out  1  high in SOF through CRC.
- crc_enable  out  1  high in SOF through DATA.
- busy  out  1  high whenever the state is not IDLE.
- tx_ack  out  1  one-cycle pulse when a request is accepted.
- frame_done  out  1  one-cycle pulse when the frame completes.
- frame_abort  out  1  one-cycle pulse when the frame is aborted.
- frame_type_out  out  1  latched frame type.
- dlc_out  out  4  latched DLC.

## Operation
- Field codes and lengths in non-stuff bits:
  - IDLE 0
  - SOF 1 (1 bit), ID 2 (11), RTR 3 (1), IDE 4 (1), R0 5 (1), DLC 6 (4)
  - DATA 7 (8 × min(dlc, 8))
  - CRC 8 (15), CRC_DEL 9 (1), ACK 10 (1), ACK_DEL 11 (1), EOF 12 (7), IFS 13 (3)
- Qualified bit: sample_point && !stuff_bit_inserted. Only qualified bits advance bit_index.
- IDLE:
  - When tx_request && enable, latch frame_type_in and dlc_in, pulse tx_ack, and enter SOF.
  - tx_request is ignored while busy.
- In any field, a qualified bit with bit_index == len−1 moves to the next field code. bit_index clears to 0 and field_start pulses.
- DATA is skipped (DLC goes straight to CRC) when frame_type == 1 or dlc == 0.
- A DLC value of 9–15 is treated as 8 bytes (64 bits). dlc_out still holds the raw value.
- The last qualified bit of the final field (IFS, or EOF; see Configuration) returns to IDLE and pulses frame_done.
- Abort:
  - Triggers on bit_error in any non-IDLE field, or on arbitration_lost in ID or RTR.
  - Returns to IDLE and pulses frame_abort; frame_done is not pulsed.
  - Abort takes priority over a simultaneous qualified bit.
- enable low mid-frame: IDLE on the next edge; no frame_abort pulse.
- Reset values (also applied when enable is low):
  - field = 0, bit_index = 0, dlc_out = 0
  - field_start, stuff_enable, crc_enable, busy, tx_ack, frame_done, frame_abort, frame_type_out = 0

## Timing
- All outputs are registered.
- Acceptance:
  - The request is seen at cycle N; at N+1, field = 1, busy = 1, tx_ack = 1 and field_start = 1.
- Field transition:
  - A qualified last bit at cycle N gives the new field code, bit_index = 0 and field_start = 1 at N+1.
- Bit index: a qualified bit at cycle N updates bit_index at N+1.
- Completion: the final qualified bit at cycle N gives field = 0, busy = 0 and frame_done = 1 at N+1.
- Abort: the error seen at cycle N gives IDLE and frame_abort = 1 at N+1.
- Back-to-back frames: a new request is accepted no earlier than the first cycle after busy falls.
- stuff_enable and crc_enable are decoded from the registered field code; they change in the same cycle as field.

## Configuration
- CAN_SEQ_IFS_EN defined:
  - EOF is followed by IFS (3 qualified bits).
  - frame_done pulses after IFS.
- CAN_SEQ_IFS_EN undefined:
  - The IFS state is absent; code 13 is never produced.
  - frame_done pulses after the last EOF bit.

## Test plan
- Data frame, dlc = 1, every sample point qualified, IFS_EN defined → field sequence 1..13 with field_start on each; 55 qualified bits to frame_done; crc_enable high through DATA; stuff_enable high through CRC.
- Remote frame, dlc = 5 → DATA skipped (field goes 6 → 8); 47 qualified bits to frame_done; frame_type_out = 1, dlc_out = 5.
- Data frame, dlc = 12 → DATA lasts 64 qualified bits (bit_index reaches 63); 111 bits total; dlc_out = 12.
- stuff_bit_inserted high on 3 sample points inside ID → ID still ends after exactly 11 qualified bits; bit_index does not change on stuffed samples.
- bit_error together with a qualified bit at CRC bit_index 7 → next cycle IDLE, frame_abort = 1, frame_done = 0; arbitration_lost asserted in CRC → ignored.
- enable dropped in DATA → IDLE with all outputs at reset values and no frame_abort; with IFS_EN undefined, the dlc = 1 frame completes in 52 qualified bits.
